// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit beside the EX-stage ALU: shift-add multiply and
// restoring divide, one step per cycle, writing the architectural HI/LO registers.
module ex_muldiv_unit #(
    parameter int DATA_SZ = 32,
    parameter int CNT_SZ  = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [1:0]         i_op,
    input  logic [DATA_SZ-1:0] i_rs_data,
    input  logic [DATA_SZ-1:0] i_rt_data,
    input  logic               i_mthi,
    input  logic               i_mtlo,
    input  logic               i_hilo_read,
    output logic [DATA_SZ-1:0] o_hi,
    output logic [DATA_SZ-1:0] o_lo,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_stall,
    output logic               o_div_zero
);

    localparam int ACC_SZ = 2 * DATA_SZ;
    localparam logic [CNT_SZ-1:0] LAST_CNT = CNT_SZ'(DATA_SZ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic [CNT_SZ-1:0]   cnt_q,      cnt_d;
    logic [ACC_SZ-1:0]   acc_q,      acc_d;
    logic [DATA_SZ-1:0]  opnd_q,     opnd_d;
    logic                is_div_q,   is_div_d;
    logic                neg_res_q,  neg_res_d;
    logic                neg_rem_q,  neg_rem_d;
    logic [DATA_SZ-1:0]  hi_q,       hi_d;
    logic [DATA_SZ-1:0]  lo_q,       lo_d;
    logic                done_q,     done_d;
    logic                div_zero_q, div_zero_d;

    logic [DATA_SZ:0]    mul_sum_s;
    logic [ACC_SZ-1:0]   mul_next_s;
    logic [DATA_SZ:0]    div_shift_s;
    logic [DATA_SZ:0]    div_diff_s;
    logic [ACC_SZ-1:0]   div_next_s;
    logic [ACC_SZ-1:0]   fix_prod_s;
    logic [DATA_SZ-1:0]  fix_quo_s;
    logic [DATA_SZ-1:0]  fix_rem_s;

    // Magnitude of an operand; unsigned operations pass the value through.
    function automatic logic [DATA_SZ-1:0] mag(input logic [DATA_SZ-1:0] v, input logic is_signed);
        if (is_signed && v[DATA_SZ-1]) begin
            return ~v + DATA_SZ'(1);
        end else begin
            return v;
        end
    endfunction

    // Conditional two's-complement negate for the sign-correction step.
    function automatic logic [DATA_SZ-1:0] neg_if(input logic [DATA_SZ-1:0] v, input logic neg);
        if (neg) begin
            return ~v + DATA_SZ'(1);
        end else begin
            return v;
        end
    endfunction

    // Single datapath step: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[ACC_SZ-1:DATA_SZ]} + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_SZ+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_q[DATA_SZ-1:1]};
        div_shift_s = {acc_q[ACC_SZ-1:DATA_SZ], acc_q[DATA_SZ-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_q};
        // Compare rather than use the borrow: the shifted remainder is DATA_SZ+1 bits wide.
        if (div_shift_s >= {1'b0, opnd_q}) begin
            div_next_s = {div_diff_s[DATA_SZ-1:0], acc_q[DATA_SZ-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[DATA_SZ-1:0], acc_q[DATA_SZ-2:0], 1'b0};
        end
    end

    // Sign-corrected results presented to HI/LO in FIX.
    always_comb begin
        if (neg_res_q) begin
            fix_prod_s = ~acc_q + ACC_SZ'(1);
        end else begin
            fix_prod_s = acc_q;
        end
        fix_quo_s = neg_if(acc_q[DATA_SZ-1:0], neg_res_q);
        fix_rem_s = neg_if(acc_q[ACC_SZ-1:DATA_SZ], neg_rem_q);
    end

    // Next-state and register-update logic for the IDLE/RUN/FIX sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    is_div_d   = i_op[1];
                    neg_res_d  = i_op[0] & (i_rs_data[DATA_SZ-1] ^ i_rt_data[DATA_SZ-1]);
                    neg_rem_d  = i_op[0] & i_op[1] & i_rs_data[DATA_SZ-1];
                    cnt_d      = {CNT_SZ{1'b0}};
                    div_zero_d = i_op[1] && (i_rt_data == {DATA_SZ{1'b0}});
                    state_d    = ST_RUN;
                    if (i_op[1]) begin
                        acc_d  = {{DATA_SZ{1'b0}}, mag(i_rs_data, i_op[0])};
                        opnd_d = mag(i_rt_data, i_op[0]);
                    end else begin
                        acc_d  = {{DATA_SZ{1'b0}}, mag(i_rt_data, i_op[0])};
                        opnd_d = mag(i_rs_data, i_op[0]);
                    end
                end else begin
                    // A start in the same cycle wins; moves only land when no op is issued.
                    if (i_mthi) begin
                        hi_d = i_rs_data;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (i_mtlo) begin
                        lo_d = i_rs_data;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_SZ'(1);
                if (is_div_q) begin
                    acc_d = div_next_s;
                end else begin
                    acc_d = mul_next_s;
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIX: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (is_div_q) begin
                    // Zero divisor: the remainder path already reproduces rs; LO is forced to all ones.
                    hi_d = fix_rem_s;
                    if (div_zero_q) begin
                        lo_d = {DATA_SZ{1'b1}};
                    end else begin
                        lo_d = fix_quo_s;
                    end
                end else begin
                    hi_d = fix_prod_s[ACC_SZ-1:DATA_SZ];
                    lo_d = fix_prod_s[DATA_SZ-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_SZ{1'b0}};
            acc_q      <= {ACC_SZ{1'b0}};
            opnd_q     <= {DATA_SZ{1'b0}};
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= {DATA_SZ{1'b0}};
            lo_q       <= {DATA_SZ{1'b0}};
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign o_hi       = hi_q;
    assign o_lo       = lo_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;
    assign o_div_zero = div_zero_q;
    assign o_stall    = (state_q != ST_IDLE) && i_hilo_read;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU.
- Consumes the registered rs/rt operands and control from the ID/EX pipeline register and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO into architectural HI/LO registers.
- Uses one shift-add or restoring-divide step per cycle.
- Drives a stall request to the hazard unit while an MFHI/MFLO would read an unfinished result.

Parameters:
- DATA_SZ, 32, operand width and width of each of HI and LO.
- CNT_SZ, 6, iteration counter width; must satisfy 2^CNT_SZ > DATA_SZ.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  start an operation; sampled only in IDLE.
- i_op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- i_rs_data  in  DATA_SZ  multiplicand/dividend; also MTHI/MTLO write data.
- i_rt_data  in  DATA_SZ  multiplier/divisor.
- i_mthi  in  1  write i_rs_data into HI.
- i_mtlo  in  1  write i_rs_data into LO.
- i_hilo_read  in  1  an MFHI/MFLO is currently in EX.
- o_hi  out  DATA_SZ  HI register.
- o_lo  out  DATA_SZ  LO register.
- o_busy  out  1  operation in progress (state != IDLE).
- o_done  out  1  one-cycle pulse: HI/LO just updated by a mul/div.
- o_stall  out  1  stall request to the hazard unit.
- o_div_zero  out  1  last DIV/DIVU had a zero divisor; held until the next accepted start.

Behaviour:
- Reset:
  - State IDLE; o_hi=0, o_lo=0, o_busy=0, o_done=0, o_div_zero=0.
  - Counter and internal accumulator/shift registers cleared.
  - Reset mid-operation aborts the operation; no HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE, i_start=1 at edge E0:
  - Latch the op, the operand magnitudes (signed ops take the absolute value of negative operands) and the result signs.
  - Product/quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - Clear the counter; o_div_zero <= (op is divide) && (i_rt_data == 0); go to RUN.
- RUN:
  - One iteration per edge, counter increments.
  - Multiply: shift-add on a 2*DATA_SZ accumulator, LSB-first.
  - Divide: restoring divide, one quotient bit per edge, MSB-first.
  - After DATA_SZ iterations (edges E1..E32 at the default width) go to FIX.
- FIX, edge E33:
  - Apply sign correction (two's-complement negate where the sign is negative).
  - Write HI/LO: multiply gives HI = upper half, LO = lower half; divide gives LO = quotient, HI = remainder.
  - Go to IDLE; o_done=1 for exactly the cycle after E33.
- Latency:
  - o_busy is high for DATA_SZ+1 cycles after E0.
  - New HI/LO are visible the cycle after FIX.
  - A back-to-back start is accepted at the first edge after FIX.
- Divide by zero:
  - Runs the full latency for deterministic timing.
  - Result is HI = original i_rs_data, LO = all ones (both signed and unsigned); o_div_zero=1.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0; no flag.
- i_start while busy: ignored (the hazard unit prevents issue; no queueing).
- MTHI/MTLO:
  - Honoured only in IDLE, taking effect at the edge.
  - Ignored while busy.
  - i_start in the same cycle has priority and the move is dropped.
  - i_mthi and i_mtlo may both be high together; each writes its own register.
- Stall: o_stall = o_busy && i_hilo_read (combinational). It is low when IDLE, including during the o_done cycle.
- o_hi/o_lo hold their previous value throughout RUN/FIX.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> o_busy high 33 cycles; o_done pulse once; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / -1 -> LO=0x80000000, HI=0, o_div_zero=0.
- DIVU 0x12345678 / 0 -> HI=0x12345678, LO=0xFFFFFFFF, o_div_zero=1; a following MULTU 2x3 gives o_div_zero=0, LO=6, HI=0.
- Control corner cases:
  - i_hilo_read held during a DIVU -> o_stall=1 for all 33 busy cycles, 0 in the o_done cycle.
  - i_start at cycle 10 of the op -> ignored; results match the first op.
  - i_reset at cycle 15 -> IDLE, HI=LO=0, no o_done.
  - MTHI 0xA5A5A5A5 in IDLE -> HI=0xA5A5A5A5 next cycle.
